// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-RAM arbiter: owner encodings, word width,
// wait-counter width and the priority decision used by the top level.
package dmem_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_LDR  = 2'b10
    } owner_e;

    // CPU wins a collision unless the loader has been starved long enough.
    function automatic owner_e pick_owner(input logic cpu_req,
                                          input logic ldr_req,
                                          input logic starve);
        if (cpu_req && ldr_req) return starve ? OWN_LDR : OWN_CPU;
        if (cpu_req)            return OWN_CPU;
        if (ldr_req)            return OWN_LDR;
        return OWN_IDLE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU, the loader/debug port, the data RAM and the
// arbiter. The slave modport is the arbiter's view; master is the environment.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    // CPU side
    logic   cpu_req;
    word_t  cpu_addrA, cpu_addrB;
    logic   cpu_wenA, cpu_wenB;
    word_t  cpu_wdataA, cpu_wdataB;
    logic   cpu_stall;

    // loader side (port A only)
    logic   ldr_req, ldr_wen;
    word_t  ldr_addr, ldr_wdata;
    logic   ldr_gnt, ldr_rvalid;
    word_t  ldr_rdata;

    // RAM side
    word_t  mem_addrA, mem_addrB;
    logic   mem_wenA, mem_wenB;
    word_t  mem_wdataA, mem_wdataB;
    word_t  mem_qA;

    owner_e owner;

    modport slave (
        input  cpu_req, cpu_addrA, cpu_addrB, cpu_wenA, cpu_wenB,
               cpu_wdataA, cpu_wdataB,
        input  ldr_req, ldr_wen, ldr_addr, ldr_wdata,
        input  mem_qA,
        output cpu_stall, ldr_gnt, ldr_rvalid, ldr_rdata,
        output mem_addrA, mem_addrB, mem_wenA, mem_wenB,
               mem_wdataA, mem_wdataB,
        output owner
    );

    modport master (
        output cpu_req, cpu_addrA, cpu_addrB, cpu_wenA, cpu_wenB,
               cpu_wdataA, cpu_wdataB,
        output ldr_req, ldr_wen, ldr_addr, ldr_wdata,
        output mem_qA,
        input  cpu_stall, ldr_gnt, ldr_rvalid, ldr_rdata,
        input  mem_addrA, mem_addrB, mem_wenA, mem_wenB,
               mem_wdataA, mem_wdataB,
        input  owner
    );

endinterface

// File: rtl/dmem_starve_cnt.sv
// Loader starvation counter: counts consecutive cycles the loader asks for
// the RAM and is refused, saturating at LIMIT. Any grant or a dropped
// request restarts the count.
module dmem_starve_cnt
    import dmem_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ldr_req,
    input  logic             ldr_gnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(LIMIT);

    // Count refused loader cycles, hold at the limit, clear on grant or idle.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!ldr_req || ldr_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LIMIT_CNT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: one requester (CPU or loader) owns both RAM ports each
// cycle. CPU has priority; with DMEM_ARBITER_FAIR_EN defined the loader is
// forced through after STARVE_LIMIT consecutive refused cycles. Loader reads
// return mem_qA one cycle after the grant.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    owner_e grant;
    owner_e owner_q;
    logic   rd_pend;
    logic   starve;
    logic   ldr_granted;

    assign ldr_granted = (grant == OWN_LDR);

`ifdef DMEM_ARBITER_FAIR_EN
    logic [CNT_W-1:0] wait_cnt;

    dmem_starve_cnt #(
        .LIMIT    (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .ldr_req  (bus.ldr_req),
        .ldr_gnt  (ldr_granted),
        .wait_cnt (wait_cnt)
    );

    assign starve = (wait_cnt == CNT_W'(STARVE_LIMIT));
`else
    assign starve = 1'b0;
`endif

    // Owner register: remembers who held the RAM last cycle.
    always_ff @(posedge clk) begin
        if (rst) owner_q <= OWN_IDLE;
        else     owner_q <= grant;
    end

    // Pending-read flag: a granted loader read returns data next cycle.
    always_ff @(posedge clk) begin
        if (rst) rd_pend <= 1'b0;
        else     rd_pend <= ldr_granted && !bus.ldr_wen;
    end

    // Grant decision and RAM port steering for the current owner.
    // NOTE: every output gets a default before the case so no path can
    // leave a value held, which would otherwise infer a latch.
    always_comb begin
        grant          = OWN_IDLE;
        bus.mem_addrA  = '0;
        bus.mem_wenA   = 1'b0;
        bus.mem_wdataA = '0;
        bus.mem_addrB  = '0;
        bus.mem_wenB   = 1'b0;
        bus.mem_wdataB = '0;

        if (!rst) grant = pick_owner(bus.cpu_req, bus.ldr_req, starve);

        case (grant)
            OWN_CPU: begin
                bus.mem_addrA  = bus.cpu_addrA;
                bus.mem_wenA   = bus.cpu_wenA;
                bus.mem_wdataA = bus.cpu_wdataA;
                bus.mem_addrB  = bus.cpu_addrB;
                bus.mem_wenB   = bus.cpu_wenB;
                bus.mem_wdataB = bus.cpu_wdataB;
            end
            OWN_LDR: begin
                bus.mem_addrA  = bus.ldr_addr;
                bus.mem_wenA   = bus.ldr_wen;
                bus.mem_wdataA = bus.ldr_wdata;
            end
            default: ;
        endcase
    end

    assign bus.cpu_stall  = bus.cpu_req && (grant != OWN_CPU);
    assign bus.ldr_gnt    = ldr_granted;
    // A read granted just before reset must not surface during reset.
    assign bus.ldr_rvalid = rd_pend && !rst;
    assign bus.ldr_rdata  = bus.ldr_rvalid ? bus.mem_qA : '0;
    assign bus.owner      = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter. The stimulus process applies one input
// set per cycle, predicts the outcome from the arbitration rules and a plain
// memory array, and queues expectations; a negedge monitor pops and compares.
// Build with DMEM_ARBITER_FAIR_EN defined to exercise the starvation override.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int LIMIT = 4;
`ifdef DMEM_ARBITER_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct {
        logic  rst;
        logic  cpu_req, wenA, wenB;
        word_t addrA, addrB, wdataA, wdataB;
        logic  ldr_req, ldr_wen;
        word_t ldr_addr, ldr_wdata;
    } stim_t;

    typedef struct {
        owner_e owner;
        logic   stall, gnt, rvalid;
        logic   wenA, wenB;
        word_t  addrA, wdataA, addrB, wdataB;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM behind the arbiter: registered port-A read, port B wins a same-address write.
    word_t ram [65536];
    always @(posedge clk) begin
        bus.mem_qA <= ram[bus.mem_addrA];
        if (bus.mem_wenA) ram[bus.mem_addrA] <= bus.mem_wdataA;
        if (bus.mem_wenB) ram[bus.mem_addrB] <= bus.mem_wdataB;
    end

    // Reference model state
    word_t  ref_mem [65536];
    int     streak;
    owner_e last_grant;
    logic   rd_pend_m;
    word_t  rd_val_m;

    exp_t  exp_q [$];
    word_t rd_q  [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, expv, $time);
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s.rst = 1'b0; s.cpu_req = 1'b0; s.wenA = 1'b0; s.wenB = 1'b0;
        s.addrA = '0; s.addrB = '0; s.wdataA = '0; s.wdataB = '0;
        s.ldr_req = 1'b0; s.ldr_wen = 1'b0; s.ldr_addr = '0; s.ldr_wdata = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst       = ($urandom_range(0, 49) == 0);
        s.cpu_req   = ($urandom_range(0, 9) < 6);
        s.wenA      = 1'($urandom_range(0, 1));
        s.wenB      = 1'($urandom_range(0, 1));
        s.addrA     = 16'($urandom_range(0, 31));
        s.addrB     = 16'($urandom_range(0, 31));
        s.wdataA    = 16'($urandom);
        s.wdataB    = 16'($urandom);
        s.ldr_req   = 1'($urandom_range(0, 1));
        s.ldr_wen   = ($urandom_range(0, 2) == 0);
        s.ldr_addr  = 16'($urandom_range(0, 31));
        s.ldr_wdata = 16'($urandom);
        return s;
    endfunction

    // Apply one cycle of stimulus and queue what the arbiter must do with it.
    task automatic step(input stim_t s);
        exp_t   e;
        owner_e g;
        @(posedge clk);
        #1;
        rst            = s.rst;
        bus.cpu_req    = s.cpu_req;
        bus.cpu_wenA   = s.wenA;   bus.cpu_wenB   = s.wenB;
        bus.cpu_addrA  = s.addrA;  bus.cpu_addrB  = s.addrB;
        bus.cpu_wdataA = s.wdataA; bus.cpu_wdataB = s.wdataB;
        bus.ldr_req    = s.ldr_req;
        bus.ldr_wen    = s.ldr_wen;
        bus.ldr_addr   = s.ldr_addr;
        bus.ldr_wdata  = s.ldr_wdata;

        if (s.rst)                        g = OWN_IDLE;
        else if (s.cpu_req && s.ldr_req)  g = (FAIR && streak == LIMIT) ? OWN_LDR : OWN_CPU;
        else if (s.cpu_req)               g = OWN_CPU;
        else if (s.ldr_req)               g = OWN_LDR;
        else                              g = OWN_IDLE;

        e.owner  = last_grant;
        e.stall  = s.cpu_req && (g != OWN_CPU);
        e.gnt    = (g == OWN_LDR);
        e.rvalid = rd_pend_m && !s.rst;
        e.addrA = '0; e.wenA = 1'b0; e.wdataA = '0;
        e.addrB = '0; e.wenB = 1'b0; e.wdataB = '0;
        if (g == OWN_CPU) begin
            e.addrA = s.addrA; e.wenA = s.wenA; e.wdataA = s.wdataA;
            e.addrB = s.addrB; e.wenB = s.wenB; e.wdataB = s.wdataB;
        end else if (g == OWN_LDR) begin
            e.addrA = s.ldr_addr; e.wenA = s.ldr_wen; e.wdataA = s.ldr_wdata;
        end
        if (e.rvalid) rd_q.push_back(rd_val_m);
        exp_q.push_back(e);

        // advance the model past this clock edge
        rd_pend_m = (g == OWN_LDR) && !s.ldr_wen;
        rd_val_m  = ref_mem[s.ldr_addr];
        if (g == OWN_CPU) begin
            if (s.wenA) ref_mem[s.addrA] = s.wdataA;
            if (s.wenB) ref_mem[s.addrB] = s.wdataB;
        end else if (g == OWN_LDR && s.ldr_wen) begin
            ref_mem[s.ldr_addr] = s.ldr_wdata;
        end
        if (s.rst || !s.ldr_req || g == OWN_LDR) streak = 0;
        else if (streak < LIMIT)                 streak++;
        last_grant = g;
    endtask

    // Monitor: compare every DUT output against the queued expectation.
    exp_t m;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            check("owner",      {14'd0, bus.owner}, {14'd0, m.owner});
            check("cpu_stall",  {15'd0, bus.cpu_stall}, {15'd0, m.stall});
            check("ldr_gnt",    {15'd0, bus.ldr_gnt},   {15'd0, m.gnt});
            check("ldr_rvalid", {15'd0, bus.ldr_rvalid}, {15'd0, m.rvalid});
            check("mem_addrA",  bus.mem_addrA,  m.addrA);
            check("mem_wenA",   {15'd0, bus.mem_wenA}, {15'd0, m.wenA});
            check("mem_wdataA", bus.mem_wdataA, m.wdataA);
            check("mem_addrB",  bus.mem_addrB,  m.addrB);
            check("mem_wenB",   {15'd0, bus.mem_wenB}, {15'd0, m.wenB});
            check("mem_wdataB", bus.mem_wdataB, m.wdataB);
        end
        if (bus.ldr_rvalid === 1'b1) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL ldr_rvalid_extra: rvalid with no read outstanding, rdata=%h at t=%0t",
                         bus.ldr_rdata, $time);
            end else begin
                check("ldr_rdata", bus.ldr_rdata, rd_q.pop_front());
            end
        end else begin
            check("ldr_rdata_idle", bus.ldr_rdata, 16'h0000);
        end
    end

    initial begin
        stim_t s;
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        streak = 0; last_grant = OWN_IDLE; rd_pend_m = 1'b0; rd_val_m = '0;
        bus.cpu_req = 1'b0; bus.cpu_wenA = 1'b0; bus.cpu_wenB = 1'b0;
        bus.cpu_addrA = '0; bus.cpu_addrB = '0; bus.cpu_wdataA = '0; bus.cpu_wdataB = '0;
        bus.ldr_req = 1'b0; bus.ldr_wen = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;

        // reset, with requests present to confirm grants are suppressed
        s = idle_stim(); s.rst = 1'b1;
        step(s);
        s.cpu_req = 1'b1; s.wenA = 1'b1; s.ldr_req = 1'b1; s.ldr_wen = 1'b1;
        step(s);

        // loader write 0x1234 to 0x0010, then read it back
        s = idle_stim(); s.ldr_req = 1'b1; s.ldr_wen = 1'b1;
        s.ldr_addr = 16'h0010; s.ldr_wdata = 16'h1234;
        step(s);
        s.ldr_wen = 1'b0;
        step(s);
        step(idle_stim());

        // CPU write on port A
        s = idle_stim(); s.cpu_req = 1'b1; s.wenA = 1'b1;
        s.addrA = 16'h0020; s.wdataA = 16'hBEEF;
        step(s);
        step(idle_stim());

        // both held high for 20 cycles, loader reading, then CPU drops out
        s = idle_stim(); s.cpu_req = 1'b1; s.ldr_req = 1'b1; s.ldr_addr = 16'h0020;
        s.addrA = 16'h0010; s.addrB = 16'h0011;
        repeat (20) step(s);
        s.cpu_req = 1'b0;
        step(s);
        step(idle_stim());

        // loader read granted, then reset the next cycle
        s = idle_stim(); s.ldr_req = 1'b1; s.ldr_addr = 16'h0010;
        step(s);
        s = idle_stim(); s.rst = 1'b1; s.cpu_req = 1'b1; s.wenA = 1'b1; s.wenB = 1'b1;
        step(s);
        step(idle_stim());

        // loader write contending with a CPU dual-port write, then read back
        s = idle_stim(); s.cpu_req = 1'b1; s.wenA = 1'b1; s.wenB = 1'b1;
        s.addrA = 16'h0005; s.addrB = 16'h0006; s.wdataA = 16'hAAAA; s.wdataB = 16'hBBBB;
        s.ldr_req = 1'b1; s.ldr_wen = 1'b1; s.ldr_addr = 16'h0007; s.ldr_wdata = 16'hC0DE;
        repeat (LIMIT + 2) step(s);
        for (int a = 5; a <= 7; a++) begin
            s = idle_stim(); s.ldr_req = 1'b1; s.ldr_addr = 16'(a);
            step(s);
        end
        step(idle_stim());

        // randomized traffic
        repeat (1500) step(rand_stim());
        repeat (3) step(idle_stim());

        repeat (2) @(negedge clk);
        #1;
        check("exp_q_drained", 16'(exp_q.size()), 16'd0);
        check("rd_q_drained",  16'(rd_q.size()),  16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive cycles the loader may be refused while the CPU holds the RAM (range 1..15).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cpu_req  input  1  CPU requests the data RAM this cycle (any data access or PLD/PST).
REQ-005 cpu_addrA, cpu_addrB  input  16  CPU data addresses, ports A/B.
REQ-006 cpu_wenA, cpu_wenB  input  1  CPU write enables, ports A/B.
REQ-007 cpu_wdataA, cpu_wdataB  input  16  CPU write data, ports A/B.
REQ-008 cpu_stall  output  1  CPU holds PC and all request inputs this cycle.
REQ-009 ldr_req, ldr_wen  input  1  loader/debug request and write enable.
REQ-010 ldr_addr, ldr_wdata  input  16  loader address and write data (port A only).
REQ-011 ldr_gnt  output  1  loader access performed this cycle.
REQ-012 ldr_rvalid  output  1  ldr_rdata valid.
REQ-013 ldr_rdata  output  16  loader read data.
REQ-014 mem_addrA, mem_addrB  output  16  RAM addresses.
REQ-015 mem_wenA, mem_wenB  output  1  RAM write enables.
REQ-016 mem_wdataA, mem_wdataB  output  16  RAM write data.
REQ-017 mem_qA  input  16  RAM port A read data, registered (1-cycle latency).
REQ-018 owner  output  2  registered last owner: 00 IDLE, 01 CPU, 10 LDR.

Function
REQ-019 Exactly one requester SHALL own both RAM ports per cycle; grant is combinational from inputs, state and wait_cnt.
REQ-020 Owner states: IDLE (no request), CPU, LDR; owner register SHALL load the granted state each cycle.
REQ-021 cpu_req only -> CPU; ldr_req only -> LDR; neither -> IDLE.
REQ-022 Both requesting -> CPU, except in FAIR build when wait_cnt == STARVE_LIMIT -> LDR.
REQ-023 CPU owner: mem_* SHALL equal the cpu_* inputs on both ports.
REQ-024 LDR owner: port A = ldr_addr/ldr_wen/ldr_wdata; port B addr 0, wen 0, wdata 0.
REQ-025 IDLE: all mem_addr/wdata 0, all mem_wen 0.
REQ-026 cpu_stall = cpu_req AND NOT CPU grant; ldr_gnt = LDR grant.
REQ-027 Loader read (ldr_gnt, ldr_wen=0) SHALL give ldr_rvalid=1 and ldr_rdata=mem_qA exactly one cycle later; otherwise ldr_rvalid=0, ldr_rdata=0.
REQ-028 Back-to-back loader reads SHALL give back-to-back rvalid pulses, one per grant, in order.
REQ-029 wait_cnt (4 bit): +1 per cycle with ldr_req AND NOT ldr_gnt, saturating at STARVE_LIMIT; cleared on ldr_gnt or ldr_req=0.
REQ-030 A write never reaches the RAM unless its requester is granted that cycle.

Reset
REQ-031 On rst: owner=IDLE, wait_cnt=0, pending read flag cleared; ldr_rvalid=0 next cycle even if a read was granted the cycle before.
REQ-032 While rst is high, grants SHALL be suppressed: all mem_wen 0, cpu_stall=cpu_req, ldr_gnt=0.

Configuration
REQ-033 Macro DMEM_ARBITER_FAIR_EN defined: starvation override of REQ-022 active.
REQ-034 Undefined: strict CPU priority; wait_cnt logic removed; loader served only when cpu_req=0.

Structure
REQ-035 Shared package holds owner encodings (IDLE/CPU/LDR) and the 16-bit address/data width constant.
REQ-036 One sub-module, dmem_starve_cnt (wait_cnt), instantiated only under DMEM_ARBITER_FAIR_EN.

Verification
REQ-037 ldr_req=1, ldr_addr=0x0010, ldr_wen=0, cpu_req=0, mem_qA=0x1234 next cycle -> ldr_gnt=1, then ldr_rvalid=1, ldr_rdata=0x1234.
REQ-038 cpu_req=1, cpu_wenA=1, addrA=0x0020, wdataA=0xBEEF -> mem_wenA=1, mem_addrA=0x0020, cpu_stall=0, owner=01 next cycle.
REQ-039 FAIR, STARVE_LIMIT=4, both held high -> CPU granted cycles 0-3, loader granted cycle 4 with cpu_stall=1, CPU granted cycle 5.
REQ-040 Non-FAIR, both held high 20 cycles -> ldr_gnt never 1; loader granted first cycle after cpu_req drops.
REQ-041 Loader read granted, rst high next cycle -> ldr_rvalid stays 0, owner=00, mem_wen* 0.
REQ-042 Loader write with cpu_req=1 and loader granted -> mem_wenB=0, only port A written with ldr_wdata.
